float_div: RTL and testbench

- Iterative IEEE-754-style floating-point divider: quotient = aIn / bIn.
- Complements the pipelined add/sub/mul arithmetic blocks in the float library as the inverse operation of multiplication.
- Shares the same MANTISSA_SIZE/EXPONENT_SIZE parameterisation and packed sign|exponent|mantissa format.
- Multi-cycle restoring division with a start/ready/valid handshake. One operation in flight at a time.

---
 rtl/float_div.sv | 210 +++++++++++++++++++++
 tb/tb_float_div.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/float_div.sv
//==============================================================================
// Module      : float_div
// Description : Iterative floating-point divider, quotient = aIn / bIn.
//               Packed sign|exponent|mantissa format, hidden leading one.
//               Restoring division, one quotient bit per cycle, constant
//               latency. Truncating rounding, denormal inputs flushed to zero.
//               Optional macro FLOAT_DIV_SPECIAL_CASES_EN decodes all-ones
//               exponents as inf/NaN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module float_div #(
    parameter  int MANTISSA_SIZE = 23,
    parameter  int EXPONENT_SIZE = 8,
    localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [FLOAT_SIZE-1:0] aIn,
    input  logic [FLOAT_SIZE-1:0] bIn,
    output logic                  valid,
    output logic [FLOAT_SIZE-1:0] quotient
);

    localparam int CW  = $clog2(MANTISSA_SIZE + 3);
    localparam int EXW = EXPONENT_SIZE + 2;

    localparam logic [CW-1:0]         c_ITERS    = CW'(MANTISSA_SIZE + 2);
    localparam logic [CW-1:0]         c_CNT_LAST = CW'(1);
    localparam logic signed [EXW-1:0] c_BIAS     = {3'b000, {(EXPONENT_SIZE-1){1'b1}}};
    localparam logic signed [EXW-1:0] c_EXP_MAX  = {2'b00, {EXPONENT_SIZE{1'b1}}};
    localparam logic signed [EXW-1:0] c_EXP_ZERO = '0;
    localparam logic signed [EXW-1:0] c_EXP_ONE  = EXW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DIVIDE    = 2'd1,
        S_NORMALIZE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [MANTISSA_SIZE+2:0]  r_rem;
    logic [MANTISSA_SIZE-1:0]  r_mb;
    logic [MANTISSA_SIZE+1:0]  r_q;
    logic                      r_sign;
    logic signed [EXW-1:0]     r_exp;
    logic                      r_special;
    logic [FLOAT_SIZE-1:0]     r_special_val;

    // Operand field decode
    logic [EXPONENT_SIZE-1:0]  w_ea, w_eb;
    logic [MANTISSA_SIZE-1:0]  w_ma, w_mb;
    logic                      w_sign, w_a_zero, w_b_zero;
    logic [FLOAT_SIZE-1:0]     w_inf_val, w_zero_val;
    logic signed [EXW-1:0]     w_exp_init;

    assign w_ea       = aIn[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign w_eb       = bIn[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign w_ma       = aIn[MANTISSA_SIZE-1:0];
    assign w_mb       = bIn[MANTISSA_SIZE-1:0];
    assign w_sign     = aIn[FLOAT_SIZE-1] ^ bIn[FLOAT_SIZE-1];
    assign w_a_zero   = (w_ea == '0);
    assign w_b_zero   = (w_eb == '0);
    assign w_inf_val  = {w_sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
    assign w_zero_val = {w_sign, {(FLOAT_SIZE-1){1'b0}}};
    assign w_exp_init = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_BIAS;

`ifdef FLOAT_DIV_SPECIAL_CASES_EN
    localparam logic [FLOAT_SIZE-1:0] c_NAN =
        {1'b0, {EXPONENT_SIZE{1'b1}}, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

    logic w_a_max, w_b_max, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    assign w_a_max = (w_ea == {EXPONENT_SIZE{1'b1}});
    assign w_b_max = (w_eb == {EXPONENT_SIZE{1'b1}});
    assign w_a_inf = w_a_max && (w_ma == '0);
    assign w_b_inf = w_b_max && (w_mb == '0);
    assign w_a_nan = w_a_max && (w_ma != '0);
    assign w_b_nan = w_b_max && (w_mb != '0);
`endif

    logic                  w_special;
    logic [FLOAT_SIZE-1:0] w_special_val;

    // Classify operands whose result does not come from the mantissa divide
    always_comb begin
        w_special     = 1'b0;
        w_special_val = w_zero_val;
`ifdef FLOAT_DIV_SPECIAL_CASES_EN
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_special     = 1'b1;
            w_special_val = c_NAN;
        end else if (w_a_inf) begin
            w_special     = 1'b1;
            w_special_val = w_inf_val;
        end else if (w_b_inf) begin
            w_special     = 1'b1;
            w_special_val = w_zero_val;
        end else if (w_b_zero) begin
            w_special     = 1'b1;
            w_special_val = w_inf_val;
        end else if (w_a_zero) begin
            w_special     = 1'b1;
            w_special_val = w_zero_val;
        end
`else
        if (w_b_zero) begin
            w_special     = 1'b1;
            w_special_val = w_inf_val;
        end else if (w_a_zero) begin
            w_special     = 1'b1;
            w_special_val = w_zero_val;
        end
`endif
    end

    // Restoring step: trial subtract of the divisor from the partial remainder
    logic [MANTISSA_SIZE+2:0] w_div_ext, w_diff;
    logic                     w_fits;
    assign w_div_ext = {2'b01, r_mb};
    assign w_fits    = (r_rem >= w_div_ext);
    assign w_diff    = r_rem - w_div_ext;

    // Normalisation: quotient of two [1,2) mantissas lies in (0.5,2)
    logic                     w_msb;
    logic signed [EXW-1:0]    w_exp_norm;
    logic [MANTISSA_SIZE-1:0] w_mant;
    logic [FLOAT_SIZE-1:0]    w_result;

    assign w_msb      = r_q[MANTISSA_SIZE+1];
    assign w_exp_norm = w_msb ? r_exp : (r_exp - c_EXP_ONE);
    assign w_mant     = w_msb ? r_q[MANTISSA_SIZE:1] : r_q[MANTISSA_SIZE-1:0];

    // Final result selection with overflow to inf and underflow to zero
    always_comb begin
        w_result = {r_sign, w_exp_norm[EXPONENT_SIZE-1:0], w_mant};
        if (r_special) begin
            w_result = r_special_val;
        end else if (w_exp_norm >= c_EXP_MAX) begin
            w_result = {r_sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end else if (w_exp_norm <= c_EXP_ZERO) begin
            w_result = {r_sign, {(FLOAT_SIZE-1){1'b0}}};
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            ready         <= 1'b1;
            valid         <= 1'b0;
            quotient      <= '0;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_mb          <= '0;
            r_q           <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        ready         <= 1'b0;
                        r_cnt         <= c_ITERS;
                        r_rem         <= {2'b01, w_ma};
                        r_mb          <= w_mb;
                        r_q           <= '0;
                        r_sign        <= w_sign;
                        r_exp         <= w_exp_init;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
                        r_state       <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (w_fits) begin
                        r_rem <= w_diff << 1;
                        r_q   <= {r_q[MANTISSA_SIZE:0], 1'b1};
                    end else begin
                        r_rem <= r_rem << 1;
                        r_q   <= {r_q[MANTISSA_SIZE:0], 1'b0};
                    end
                    r_cnt <= r_cnt - c_CNT_LAST;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_NORMALIZE;
                    end
                end
                S_NORMALIZE: begin
                    quotient <= w_result;
                    valid    <= 1'b1;
                    ready    <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_float_div.sv
//==============================================================================
// Module      : tb_float_div
// Description : Directed-vector bench for float_div with default parameters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_float_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        valid;
    logic [31:0] quotient;

    int n_checks = 0;
    int n_errors = 0;

    float_div u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .aIn      (aIn),
        .bIn      (bIn),
        .valid    (valid),
        .quotient (quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present operands with start for one rising edge; caller ensures ready
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        aIn   = a;
        bIn   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until valid is seen, bounded
    task automatic wait_valid(output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) seen = 1'b1;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int n;
        issue(a, b);
        wait_valid(n);
        check({tag, "_lat"}, n, 26);
        check(tag, quotient, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;
        reset = 1'b1;
        start = 1'b0;
        aIn   = '0;
        bIn   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_quot",  quotient, 32'h0);

        run("6div2", 32'h40C00000, 32'h40000000, 32'h40400000);
        @(posedge clk);
        #1;
        check("ready_after", ready, 1);
        check("valid_pulse", valid, 0);

        run("1div3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        run("m1divhalf", 32'hBF800000, 32'h3F000000, 32'hC0000000);
        run("1div0",     32'h3F800000, 32'h00000000, 32'h7F800000);
        run("overflow",  32'h7F000000, 32'h00800000, 32'h7F800000);
        run("underflow", 32'h00800000, 32'h7F000000, 32'h00000000);
        run("0div1",     32'h00000000, 32'h3F800000, 32'h00000000);
        run("m0div1",    32'h80000000, 32'h3F800000, 32'h80000000);
        run("7div2",     32'h40E00000, 32'h40000000, 32'h40600000);

        // start while busy is ignored and operands are not re-sampled
        issue(32'h40C00000, 32'h40000000);
        repeat (5) @(posedge clk);
        #1;
        aIn   = 32'h3F800000;
        bIn   = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(n);
        check("busy_lat",  n, 20);
        check("busy_quot", quotient, 32'h40400000);

        // back-to-back start in the cycle ready returns
        check("b2b_ready", ready, 1);
        run("b2b", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);

        // reset in the middle of a divide
        issue(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_quot",  quotient, 32'h0);
        nv = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("mid_rst_novalid", nv, 0);
        run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

`ifdef FLOAT_DIV_SPECIAL_CASES_EN
        run("inf_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000);
        run("nan_1",    32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        run("1_minf",   32'h3F800000, 32'hFF800000, 32'h80000000);
        run("0div0",    32'h00000000, 32'h00000000, 32'h7FC00000);
`else
        run("0div0",    32'h00000000, 32'h00000000, 32'h7F800000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
